// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fc_pkg
// Description : Shared constants and FSM state encoding for the FC datapath
//               (MAC array and result streamer).
// Revision    : 1.0 - initial release
// ============================================================================
package fc_pkg;

    localparam int NUM_OUTPUTS = 10;
    localparam int ACC_WIDTH   = 32;
    localparam int OUT_WIDTH   = 8;
    localparam int SHIFT_WIDTH = 5;
    localparam int IDX_WIDTH   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage : fc_pkg
`default_nettype wire

// File: rtl/fc_requant.sv
`default_nettype none
// ============================================================================
// Module      : fc_requant
// Description : Unsigned requantizer. Right-shifts an accumulator and
//               saturates the result to OUT_WIDTH bits. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_requant #(
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic [ACC_WIDTH-1:0]   acc_i,
    input  logic [SHIFT_WIDTH-1:0] shift_i,
    output logic [OUT_WIDTH-1:0]   data_o
);

    // Largest value representable in the output word, widened to ACC_WIDTH.
    localparam logic [ACC_WIDTH-1:0] SAT_LIMIT =
        {{(ACC_WIDTH-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

    logic [ACC_WIDTH-1:0] shifted;

    // Shift (oversized shifts flush to zero), then clamp to the output range.
    always_comb begin
        shifted = '0;
        if (int'(shift_i) < ACC_WIDTH) begin
            shifted = acc_i >> shift_i;
        end
        if (shifted > SAT_LIMIT) begin
            data_o = '1;
        end else begin
            data_o = shifted[OUT_WIDTH-1:0];
        end
    end

endmodule : fc_requant
`default_nettype wire

// File: rtl/fc_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : fc_result_streamer
// Description : Captures the FC MAC array accumulators on its finish pulse,
//               streams requantized results over valid/ready and reports the
//               argmax (predicted class) once the stream has completed.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_result_streamer #(
    parameter int NUM_OUTPUTS = fc_pkg::NUM_OUTPUTS,
    parameter int ACC_WIDTH   = fc_pkg::ACC_WIDTH,
    parameter int OUT_WIDTH   = fc_pkg::OUT_WIDTH,
    parameter int SHIFT_WIDTH = fc_pkg::SHIFT_WIDTH,
    parameter int IDX_WIDTH   = fc_pkg::IDX_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             finish_in,
    input  logic [ACC_WIDTH*NUM_OUTPUTS-1:0] data_in_flat,
    input  logic [SHIFT_WIDTH-1:0]           shift_amt,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [OUT_WIDTH-1:0]             m_data,
    output logic [IDX_WIDTH-1:0]             m_index,
    output logic                             m_last,
    output logic                             class_valid,
    output logic [IDX_WIDTH-1:0]             class_idx,
    output logic [ACC_WIDTH-1:0]             class_score,
    output logic                             busy,
    output logic                             drop
);

    import fc_pkg::*;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_OUTPUTS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_q;
    logic [ACC_WIDTH-1:0]   cap_q [NUM_OUTPUTS];
    logic [SHIFT_WIDTH-1:0] shift_q;
    logic [IDX_WIDTH-1:0]   idx_q;

    logic [IDX_WIDTH-1:0]   best_idx_q;
    logic [ACC_WIDTH-1:0]   best_score_q;
    logic                   first_q;

    logic                   m_valid_q;
    logic                   m_last_q;
    logic                   class_valid_q;
    logic [IDX_WIDTH-1:0]   class_idx_q;
    logic [ACC_WIDTH-1:0]   class_score_q;
    logic                   busy_q;
    logic                   drop_q;

    // Running argmax including the beat currently on the bus.
    logic [ACC_WIDTH-1:0]   cur_acc;
    logic                   take;
    logic [IDX_WIDTH-1:0]   best_idx_d;
    logic [ACC_WIDTH-1:0]   best_score_d;

    // ------------------------------------------------------------------
    // Requantization of the current beat (registered inputs only)
    // ------------------------------------------------------------------
    fc_requant #(
        .ACC_WIDTH   (ACC_WIDTH),
        .OUT_WIDTH   (OUT_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_requant (
        .acc_i   (cur_acc),
        .shift_i (shift_q),
        .data_o  (m_data)
    );

    // Argmax candidate: first beat always wins, later beats only when strictly larger.
    always_comb begin
        cur_acc      = cap_q[idx_q];
        take         = first_q || (cur_acc > best_score_q);
        best_idx_d   = best_idx_q;
        best_score_d = best_score_q;
        if (take) begin
            best_idx_d   = idx_q;
            best_score_d = cur_acc;
        end
    end

    // Control FSM with capture buffer, argmax tracking and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                cap_q[i] <= '0;
            end
            shift_q       <= '0;
            idx_q         <= '0;
            best_idx_q    <= '0;
            best_score_q  <= '0;
            first_q       <= 1'b0;
            m_valid_q     <= 1'b0;
            m_last_q      <= 1'b0;
            class_valid_q <= 1'b0;
            class_idx_q   <= '0;
            class_score_q <= '0;
            busy_q        <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            // A finish pulse arriving while a result set is still in flight is lost.
            drop_q        <= finish_in && (state_q != IDLE);
            class_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (finish_in) begin
                        for (int i = 0; i < NUM_OUTPUTS; i++) begin
                            cap_q[i] <= data_in_flat[i*ACC_WIDTH +: ACC_WIDTH];
                        end
                        shift_q      <= shift_amt;
                        idx_q        <= '0;
                        best_idx_q   <= '0;
                        best_score_q <= '0;
                        first_q      <= 1'b1;
                        m_valid_q    <= 1'b1;
                        m_last_q     <= (LAST_IDX == '0);
                        busy_q       <= 1'b1;
                        state_q      <= STREAM;
                    end
                end

                STREAM: begin
                    if (m_ready) begin
                        best_idx_q   <= best_idx_d;
                        best_score_q <= best_score_d;
                        first_q      <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            // Publish the argmax including this final beat.
                            m_valid_q     <= 1'b0;
                            m_last_q      <= 1'b0;
                            class_valid_q <= 1'b1;
                            class_idx_q   <= best_idx_d;
                            class_score_q <= best_score_d;
                            state_q       <= DONE;
                        end else begin
                            idx_q    <= idx_q + 1'b1;
                            m_last_q <= ((idx_q + 1'b1) == LAST_IDX);
                        end
                    end
                end

                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    m_valid_q <= 1'b0;
                    m_last_q  <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign m_valid     = m_valid_q;
    assign m_index     = idx_q;
    assign m_last      = m_last_q;
    assign class_valid = class_valid_q;
    assign class_idx   = class_idx_q;
    assign class_score = class_score_q;
    assign busy        = busy_q;
    assign drop        = drop_q;

endmodule : fc_result_streamer
`default_nettype wire

// File: tb/tb_fc_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fc_result_streamer
// Description : Directed self-checking bench for fc_result_streamer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_result_streamer;

    localparam int N  = 10;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          finish_in = 1'b0;
    logic [AW*N-1:0] data_in_flat = '0;
    logic [4:0]    shift_amt = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [7:0]    m_data;
    logic [3:0]    m_index;
    logic          m_last;
    logic          class_valid;
    logic [3:0]    class_idx;
    logic [31:0]   class_score;
    logic          busy;
    logic          drop;

    logic [31:0]   acc [N];
    int            tests = 0;
    int            fails = 0;

    fc_result_streamer dut (
        .clk          (clk),
        .rst          (rst),
        .finish_in    (finish_in),
        .data_in_flat (data_in_flat),
        .shift_amt    (shift_amt),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_index      (m_index),
        .m_last       (m_last),
        .class_valid  (class_valid),
        .class_idx    (class_idx),
        .class_score  (class_score),
        .busy         (busy),
        .drop         (drop)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) data_in_flat[i*AW +: AW] = acc[i];
    endtask

    task automatic launch(input logic [4:0] sh);
        pack();
        shift_amt = sh;
        finish_in = 1'b1;
        step();
        finish_in = 1'b0;
    endtask

    task automatic wait_class(input string tag, input logic [3:0] eidx, input logic [31:0] escore);
        int n = 0;
        while (!class_valid && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, class_valid, 1);
        chk({tag, "_idx"}, class_idx, eidx);
        chk({tag, "_score"}, class_score, escore);
        step();
    endtask

    initial begin
        int beats;
        logic acc_now;
        logic [5:0] pat;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_index", m_index, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_class_valid", class_valid, 0);
        chk("rst_class_idx", class_idx, 0);
        chk("rst_class_score", class_score, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop, 0);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("idle_m_valid", m_valid, 0);
        end
        m_ready = 1'b1;

        // ---------------- basic stream ----------------
        for (int i = 0; i < N; i++) acc[i] = 32'(i * 10);
        launch(5'd0);
        for (int k = 0; k < N; k++) begin
            chk("basic_m_valid", m_valid, 1);
            chk("basic_m_data", m_data, 64'(k * 10));
            chk("basic_m_index", m_index, 64'(k));
            chk("basic_m_last", m_last, (k == N - 1));
            chk("basic_no_class", class_valid, 0);
            chk("basic_busy", busy, 1);
            step();
        end
        chk("basic_class_valid", class_valid, 1);
        chk("basic_class_idx", class_idx, 9);
        chk("basic_class_score", class_score, 90);
        chk("basic_done_m_valid", m_valid, 0);
        step();
        chk("basic_class_pulse", class_valid, 0);
        chk("basic_idle_busy", busy, 0);
        chk("basic_class_hold", class_idx, 9);

        // ---------------- requant ----------------
        for (int i = 0; i < N; i++) acc[i] = 32'h0;
        acc[0] = 32'h0ABC;
        acc[1] = 32'h1234;
        acc[2] = 32'h000F;
        launch(5'd4);
        chk("rq_shift4", m_data, 8'hAB);
        step();
        chk("rq_saturate", m_data, 8'hFF);
        step();
        chk("rq_zero", m_data, 8'h00);
        wait_class("rq_argmax_raw", 4'd1, 32'h1234);

        for (int i = 0; i < N; i++) acc[i] = 32'hFFFF_FFFF;
        launch(5'd31);
        for (int k = 0; k < N; k++) begin
            chk("rq_shift31", m_data, 8'h01);
            step();
        end
        wait_class("rq_alleq_tie", 4'd0, 32'hFFFF_FFFF);

        // ---------------- argmax ties / zero ----------------
        acc[0] = 10;  acc[1] = 20;  acc[2] = 500; acc[3] = 30; acc[4] = 40;
        acc[5] = 50;  acc[6] = 60;  acc[7] = 500; acc[8] = 70; acc[9] = 80;
        launch(5'd2);
        wait_class("tie_lower_idx", 4'd2, 32'd500);

        for (int i = 0; i < N; i++) acc[i] = 32'h0;
        launch(5'd0);
        wait_class("all_zero", 4'd0, 32'd0);

        // ---------------- backpressure ----------------
        for (int i = 0; i < N; i++) acc[i] = 32'(i + 1);
        pat = 6'b101001;   // bit c%6 gives ready: 1,0,0,1,0,1
        launch(5'd0);
        beats = 0;
        for (int c = 0; c < 60 && beats < N; c++) begin
            chk("bp_m_valid", m_valid, 1);
            chk("bp_m_data", m_data, 64'(beats + 1));
            chk("bp_m_index", m_index, 64'(beats));
            chk("bp_m_last", m_last, (beats == N - 1));
            chk("bp_no_class", class_valid, 0);
            m_ready = pat[c % 6];
            acc_now = m_valid && m_ready;
            step();
            if (acc_now) beats++;
        end
        chk("bp_beat_count", beats, N);
        chk("bp_class_valid", class_valid, 1);
        chk("bp_class_idx", class_idx, 9);
        chk("bp_class_score", class_score, 10);
        m_ready = 1'b1;
        step();

        // ---------------- collision ----------------
        for (int i = 0; i < N; i++) acc[i] = 32'(100 - i);
        launch(5'd0);
        for (int i = 0; i < N; i++) acc[i] = 32'h0000_FFFF;
        for (int k = 0; k < N; k++) begin
            chk("col_m_valid", m_valid, 1);
            chk("col_m_index", m_index, 64'(k));
            chk("col_m_data", m_data, 64'(100 - k));
            if (k == 4) begin
                pack();
                finish_in = 1'b1;
            end
            if (k == 5) begin
                chk("col_drop_pulse", drop, 1);
                finish_in = 1'b0;
            end else begin
                chk("col_drop_quiet", drop, 0);
            end
            step();
        end
        chk("col_class_valid", class_valid, 1);
        chk("col_class_idx", class_idx, 0);
        chk("col_class_score", class_score, 100);
        finish_in = 1'b1;   // lands in DONE: dropped
        step();
        chk("col_done_drop", drop, 1);
        chk("col_done_no_stream", m_valid, 0);
        chk("col_done_idle", busy, 0);
        step();             // finish_in still high, now in IDLE: accepted
        finish_in = 1'b0;
        chk("col_accept_m_valid", m_valid, 1);
        chk("col_accept_drop", drop, 0);
        chk("col_accept_data", m_data, 8'hFF);

        // ---------------- reset mid-stream ----------------
        step();
        step();
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_m_data", m_data, 0);
        chk("mid_rst_class_idx", class_idx, 0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("post_rst_m_valid", m_valid, 0);
            chk("post_rst_class_valid", class_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_fc_result_streamer
`default_nettype wire
